// File: rtl/hud_digit_sequencer_pkg.sv
// rtl/hud_digit_sequencer_pkg.sv - shared constants, FSM encoding and saturation helpers
package hud_digit_sequencer_pkg;
    localparam int BIN_W       = 14;
    localparam int BCD_W       = 4;
    localparam int SCORE_MAX   = 9999;
    localparam int TIME_MAX    = 5999;
    localparam int SEC_PER_MIN = 60;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPLIT,
        S_CONV_SC,
        S_CONV_MN,
        S_CONV_SS,
        S_COMMIT
    } state_e;

    function automatic logic [BIN_W-1:0] sat_score(input logic [BIN_W-1:0] s);
        return (s > BIN_W'(SCORE_MAX)) ? BIN_W'(SCORE_MAX) : s;
    endfunction

    function automatic logic [15:0] sat_time(input logic [15:0] s);
        return (s > 16'(TIME_MAX)) ? 16'(TIME_MAX) : s;
    endfunction
endpackage

// File: rtl/hud_digit_sequencer_if.sv
// rtl/hud_digit_sequencer_if.sv - frame request inputs and committed HUD digit outputs
interface hud_digit_sequencer_if;
    import hud_digit_sequencer_pkg::*;

    logic             frame_start_i;
    logic [31:0]      score_i;
    logic [15:0]      seconds_i;
    logic [BCD_W-1:0] thousands_o;
    logic [BCD_W-1:0] hundreds_o;
    logic [BCD_W-1:0] tens_o;
    logic [BCD_W-1:0] ones_o;
    logic [BCD_W-1:0] min1_o;
    logic [BCD_W-1:0] min0_o;
    logic [BCD_W-1:0] sec1_o;
    logic [BCD_W-1:0] sec0_o;
    logic             digits_valid_o;
    logic             done_o;
    logic             busy_o;

    modport master (
        output frame_start_i, score_i, seconds_i,
        input  thousands_o, hundreds_o, tens_o, ones_o,
        input  min1_o, min0_o, sec1_o, sec0_o,
        input  digits_valid_o, done_o, busy_o
    );

    modport slave (
        input  frame_start_i, score_i, seconds_i,
        output thousands_o, hundreds_o, tens_o, ones_o,
        output min1_o, min0_o, sec1_o, sec0_o,
        output digits_valid_o, done_o, busy_o
    );
endinterface

// File: rtl/hud_digit_sequencer_bin_to_bcd_seq.sv
// rtl/hud_digit_sequencer_bin_to_bcd_seq.sv - serial 14-bit double-dabble binary to 4-digit BCD
module bin_to_bcd_seq
    import hud_digit_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [BIN_W-1:0]     bin_i,
    output logic [4*BCD_W-1:0]   bcd_o,
    output logic                 ready_o
);
    localparam int SH_W = 4*BCD_W + BIN_W;

    logic [SH_W-1:0] sh_q, sh_d, adj;
    logic [3:0]      cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        adj   = sh_q;
        if (start_i) begin
            sh_d  = {{(4*BCD_W){1'b0}}, bin_i};
            cnt_d = 4'(BIN_W);
        end else if (cnt_q != 4'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (adj[BIN_W+BCD_W*i +: BCD_W] >= 4'd5)
                    adj[BIN_W+BCD_W*i +: BCD_W] = adj[BIN_W+BCD_W*i +: BCD_W] + 4'd3;
            end
            sh_d  = {adj[SH_W-2:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o   = sh_q[SH_W-1:BIN_W];
    assign ready_o = (cnt_q == 4'd0);
endmodule

// File: rtl/hud_digit_sequencer.sv
// rtl/hud_digit_sequencer.sv - per-frame score/time capture, minute split, BCD conversion and atomic digit commit
module hud_digit_sequencer
    import hud_digit_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    hud_digit_sequencer_if.slave  hud
);
    state_e              state_q, state_d;
    logic                fs_q, req_q, req_d;
    logic                pending_q, pending_d;
    logic [BIN_W-1:0]    score_q, score_d;
    logic [15:0]         rem_q, rem_d;
    logic [6:0]          min_q, min_d;
    logic [4*BCD_W-1:0]  sc_bcd_q, sc_bcd_d;
    logic [2*BCD_W-1:0]  mn_bcd_q, mn_bcd_d, ss_bcd_q, ss_bcd_d;
    logic [8*BCD_W-1:0]  digits_q, digits_d;
    logic                valid_q, valid_d, done_q, done_d;
    logic                conv_start, conv_ready;
    logic [BIN_W-1:0]    conv_bin;
    logic [4*BCD_W-1:0]  conv_bcd;

    bin_to_bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (conv_bin),
        .bcd_o   (conv_bcd),
        .ready_o (conv_ready)
    );

    assign req_d = hud.frame_start_i & ~fs_q;

    // The converter is started on the edge that enters each CONV state, so each state lasts 15 cycles.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | (req_q & (state_q != S_IDLE));
        score_d    = score_q;
        rem_d      = rem_q;
        min_d      = min_q;
        sc_bcd_d   = sc_bcd_q;
        mn_bcd_d   = mn_bcd_q;
        ss_bcd_d   = ss_bcd_q;
        digits_d   = digits_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        conv_start = 1'b0;
        conv_bin   = score_q;
        case (state_q)
            S_IDLE: if (req_q) begin
                score_d = sat_score(hud.score_i[BIN_W-1:0]);
                rem_d   = sat_time(hud.seconds_i);
                min_d   = '0;
                state_d = S_SPLIT;
            end
            S_SPLIT: if (rem_q >= 16'(SEC_PER_MIN)) begin
                rem_d = rem_q - 16'(SEC_PER_MIN);
                min_d = min_q + 7'd1;
            end else begin
                conv_start = 1'b1;
                state_d    = S_CONV_SC;
            end
            S_CONV_SC: if (conv_ready) begin
                sc_bcd_d   = conv_bcd;
                conv_start = 1'b1;
                conv_bin   = {{(BIN_W-7){1'b0}}, min_q};
                state_d    = S_CONV_MN;
            end
            S_CONV_MN: if (conv_ready) begin
                mn_bcd_d   = conv_bcd[2*BCD_W-1:0];
                conv_start = 1'b1;
                conv_bin   = rem_q[BIN_W-1:0];
                state_d    = S_CONV_SS;
            end
            S_CONV_SS: if (conv_ready) begin
                ss_bcd_d = conv_bcd[2*BCD_W-1:0];
                state_d  = S_COMMIT;
            end
            S_COMMIT: begin
                digits_d  = {sc_bcd_q, mn_bcd_q, ss_bcd_q};
                done_d    = 1'b1;
                valid_d   = 1'b1;
                pending_d = 1'b0;
                if (pending_q || req_q) begin
                    score_d = sat_score(hud.score_i[BIN_W-1:0]);
                    rem_d   = sat_time(hud.seconds_i);
                    min_d   = '0;
                    state_d = S_SPLIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            fs_q      <= 1'b0;
            req_q     <= 1'b0;
            pending_q <= 1'b0;
            score_q   <= '0;
            rem_q     <= '0;
            min_q     <= '0;
            sc_bcd_q  <= '0;
            mn_bcd_q  <= '0;
            ss_bcd_q  <= '0;
            digits_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fs_q      <= hud.frame_start_i;
            req_q     <= req_d;
            pending_q <= pending_d;
            score_q   <= score_d;
            rem_q     <= rem_d;
            min_q     <= min_d;
            sc_bcd_q  <= sc_bcd_d;
            mn_bcd_q  <= mn_bcd_d;
            ss_bcd_q  <= ss_bcd_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign {hud.thousands_o, hud.hundreds_o, hud.tens_o, hud.ones_o,
            hud.min1_o, hud.min0_o, hud.sec1_o, hud.sec0_o} = digits_q;
    assign hud.digits_valid_o = valid_q;
    assign hud.done_o         = done_q;
    assign hud.busy_o         = (state_q != S_IDLE);
endmodule
